dot_result_writeback: RTL and testbench
=======================================

// Module: dot_result_writeback
// PURPOSE
//  Downstream of the DMA dot-product engine; mapped at 0x50000100.
//  Accepts Q32.32 64-bit accumulator results over valid/ready, requantizes each to
//  Q16.16 (round, bias, saturate, optional ReLU), and buffers COUNT results.
//  Writes them to SDRAM as one 32-bit burst; firmware then programs the next layer.
// PARAMETERS
//  BUF_DEPTH  256  max results per burst; COUNT is clamped to this
// PORTS
//  clk             in   1   system clock
//  reset_n         in   1   synchronous active-low reset
//  reg_valid       in   1   CPU register access strobe
//  reg_write       in   1   1=write, 0=read
//  reg_addr        in   8   byte address, decoded on [7:2]
//  reg_wdata       in   32  write data
//  reg_rdata       out  32  combinational read data
//  reg_ready       out  1   = reg_valid (zero-wait)
//  res_valid       in   1   result word offered
//  res_data        in   64  signed Q32.32 accumulator
//  res_ready       out  1   result accepted when valid&ready
//  burst_wr        out  1   one-cycle burst-write request pulse
//  burst_addr      out  25  SDRAM half-word address = {ADDR_OUT,1'b0}
//  burst_len       out  11  half-words = 2*COUNT
//  burst_32bit     out  1   tied 1
//  burst_wdata     out  32  current write word
//  burst_data_req  in   1   sink consumes burst_wdata this cycle
//  burst_data_done in   1   burst finished
// BEHAVIOUR
//  Regs: 0x00 CTRL W:[0]start [1]relu_en; R:{29'b0,sat_flag,relu_en,busy}
//        0x04 COUNT[8:0]  0x08 ADDR_OUT[23:0] word addr  0x0C BIAS Q16.16 signed
//        0x10 SAT_COUNT[15:0] (RO; cleared on start). Writes ignored while busy.
//  Write side effects occur once per access (hold until reg_valid drops).
//  Reset: busy=0, state IDLE, all regs 0, res_ready=0, burst_wr=0,
//         burst_addr/len/wdata=0, reg_rdata decodes reset regs.
//  States: IDLE -start-> COLLECT (count_eff=min(COUNT,BUF_DEPTH); COUNT=0 -> DONE)
//    COLLECT: res_ready=1 while accepted<count_eff; ->FLUSH when pipe has
//      written count_eff entries.
//    FLUSH (1 cyc): burst_wr=1, burst_wdata<=buf[0], rd_idx<=1 -> BURST.
//    BURST: on burst_data_req: burst_wdata<=buf[rd_idx], rd_idx++ (sink samples
//      the word present in the req cycle); on burst_data_done -> DONE, even if
//      fewer reqs were seen. DONE (1 cyc): busy<=0 -> IDLE.
//  res_ready is 0 in every state except COLLECT; no results are dropped or held.
//  Pipeline, 2 stages, 1 result/cycle:
//    S1: t = ((res_data + 2^15) >>> 16) + sext(BIAS)  (50-bit signed,
//        round half toward +inf)
//    S2: t>2^31-1 -> 0x7FFFFFFF; t<-2^31 -> 0x80000000; either case sets
//        sat_flag and SAT_COUNT++ (saturating at 0xFFFF);
//        then relu_en & negative -> 0; write buf[wr_idx++].
//  Accept-to-buffer latency = 2 cycles; last accept -> burst_wr = 3 cycles.
//  Reset asserted mid-operation: return to IDLE next edge; burst_wr/res_ready low;
//  buffer contents undefined, not read.
// TESTING
//  COUNT=1, BIAS=0, res=0x0000_0001_0000_8000 -> word 0x0001_0001
//  res=0xFFFF_FFFF_FFFF_8000 -> 0x0000_0000 (half rounds up)
//  res=0x0001_0000_0000_0000 -> 0x7FFFFFFF, SAT_COUNT=1; res=0x8000_0000_0000_0000
//    -> 0x80000000, SAT_COUNT=2
//  relu_en=1, BIAS=0x0000_8000, res=-0x1_0000_0000 -> 0x0000_0000
//  COUNT=4, ADDR_OUT=0x1000, back-to-back results with a stalled source cycle ->
//    one burst_wr, addr 0x2000, len 8, 4 words in order; burst_data_req gaps honoured
//  COUNT=0 start -> busy=1 for two cycles, no burst_wr
//  COUNT=300 -> clamped to 256, len 512
//  reset_n low mid-BURST -> IDLE, busy 0, outputs at reset values

Source files
------------

// File: rtl/dot_result_writeback.sv
// Result writeback block: requantizes Q32.32 accumulator results to Q16.16 and
// buffers them, then streams the buffer to SDRAM as a single 32-bit burst.
module dot_result_writeback #(
   parameter int unsigned BUF_DEPTH = 256
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        reg_valid,
   input  logic        reg_write,
   input  logic [7:0]  reg_addr,
   input  logic [31:0] reg_wdata,
   output logic [31:0] reg_rdata,
   output logic        reg_ready,
   input  logic        res_valid,
   input  logic [63:0] res_data,
   output logic        res_ready,
   output logic        burst_wr,
   output logic [24:0] burst_addr,
   output logic [10:0] burst_len,
   output logic        burst_32bit,
   output logic [31:0] burst_wdata,
   input  logic        burst_data_req,
   input  logic        burst_data_done
);

   localparam int unsigned AW      = $clog2(BUF_DEPTH);
   localparam logic [8:0]  DEPTH_C = 9'(BUF_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_FLUSH,
      S_BURST,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic        relu_q, sat_flag_q, reg_seen_q;
   logic [8:0]  count_q, cnt_eff_q, acc_q, wr_q, rd_q;
   logic [23:0] addr_q;
   logic [31:0] bias_q, wdata_q;
   logic [15:0] sat_cnt_q;
   logic        v1_q;
   logic [49:0] t1_q, t1_d;
   logic [31:0] mem [BUF_DEPTH];

   logic        busy, reg_we, start, accept;
   logic [64:0] rnd;
   logic        pos_sat, neg_sat;
   logic [31:0] clamped, wr_word;
   logic        unused_bits;

   assign busy   = (state_q != S_IDLE);
   // One side effect per access: only the first cycle of a held strobe writes.
   assign reg_we = reg_valid & reg_write & ~reg_seen_q & ~busy;
   assign start  = reg_we && (reg_addr[7:2] == 6'd0) && reg_wdata[0];
   assign accept = res_valid & res_ready;

   // Stage 1: round half toward +inf at bit 16, then add sign-extended bias.
   assign rnd  = {res_data[63], res_data} + 65'd32768;
   assign t1_d = {rnd[64], rnd[64:16]} + {{18{bias_q[31]}}, bias_q};

   // Stage 2: saturate to 32-bit signed, then optional ReLU.
   assign pos_sat = ~t1_q[49] & (|t1_q[48:31]);
   assign neg_sat =  t1_q[49] & ~(&t1_q[48:31]);
   assign clamped = pos_sat ? 32'h7FFF_FFFF : (neg_sat ? 32'h8000_0000 : t1_q[31:0]);
   assign wr_word = (relu_q & clamped[31]) ? '0 : clamped;

   assign unused_bits = ^{reg_addr[1:0], rnd[15:0]};

   assign reg_ready   = reg_valid;
   assign res_ready   = (state_q == S_COLLECT) && (acc_q < cnt_eff_q);
   assign burst_wr    = (state_q == S_FLUSH);
   assign burst_addr  = {addr_q, 1'b0};
   assign burst_len   = {1'b0, cnt_eff_q, 1'b0};
   assign burst_32bit = 1'b1;
   assign burst_wdata = wdata_q;

   always_comb begin
      reg_rdata = '0;
      case (reg_addr[7:2])
         6'd0:    reg_rdata = {29'd0, sat_flag_q, relu_q, busy};
         6'd1:    reg_rdata = {23'd0, count_q};
         6'd2:    reg_rdata = {8'd0, addr_q};
         6'd3:    reg_rdata = bias_q;
         6'd4:    reg_rdata = {16'd0, sat_cnt_q};
         default: reg_rdata = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start) state_d = S_COLLECT;
         S_COLLECT: begin
            if (cnt_eff_q == 9'd0)     state_d = S_DONE;
            else if (wr_q == cnt_eff_q) state_d = S_FLUSH;
         end
         S_FLUSH:   state_d = S_BURST;
         S_BURST:   if (burst_data_done) state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         relu_q     <= 1'b0;
         sat_flag_q <= 1'b0;
         reg_seen_q <= 1'b0;
         count_q    <= '0;
         cnt_eff_q  <= '0;
         acc_q      <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         addr_q     <= '0;
         bias_q     <= '0;
         wdata_q    <= '0;
         sat_cnt_q  <= '0;
         v1_q       <= 1'b0;
         t1_q       <= '0;
      end else begin
         reg_seen_q <= reg_valid;
         if (reg_we) begin
            case (reg_addr[7:2])
               6'd0:    relu_q  <= reg_wdata[1];
               6'd1:    count_q <= reg_wdata[8:0];
               6'd2:    addr_q  <= reg_wdata[23:0];
               6'd3:    bias_q  <= reg_wdata;
               default: ;
            endcase
         end

         if (start) begin
            cnt_eff_q  <= (count_q > DEPTH_C) ? DEPTH_C : count_q;
            acc_q      <= '0;
            wr_q       <= '0;
            sat_flag_q <= 1'b0;
            sat_cnt_q  <= '0;
         end else begin
            if (accept) acc_q <= acc_q + 9'd1;
            if (v1_q) begin
               wr_q <= wr_q + 9'd1;
               if (pos_sat | neg_sat) begin
                  sat_flag_q <= 1'b1;
                  if (sat_cnt_q != '1) sat_cnt_q <= sat_cnt_q + 16'd1;
               end
            end
         end

         v1_q <= accept;
         if (accept) t1_q <= t1_d;

         // Word for the sink's next request is prefetched one cycle ahead.
         if (state_q == S_FLUSH) begin
            wdata_q <= mem[0];
            rd_q    <= 9'd1;
         end else if ((state_q == S_BURST) && burst_data_req) begin
            wdata_q <= mem[rd_q[AW-1:0]];
            rd_q    <= rd_q + 9'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (v1_q) mem[wr_q[AW-1:0]] <= wr_word;
   end

endmodule

// File: tb/tb_dot_result_writeback.sv
// Bench for dot_result_writeback: table vectors, randomized jobs against a
// floor-division reference model, and hand sequences for empty/clamp/reset cases.
module tb_dot_result_writeback;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        reg_valid, reg_write;
   logic [7:0]  reg_addr;
   logic [31:0] reg_wdata, reg_rdata;
   logic        reg_ready;
   logic        res_valid, res_ready;
   logic [63:0] res_data;
   logic        burst_wr, burst_32bit;
   logic [24:0] burst_addr;
   logic [10:0] burst_len;
   logic [31:0] burst_wdata;
   logic        burst_data_req, burst_data_done;

   always #5 clk = ~clk;

   dot_result_writeback #(.BUF_DEPTH(256)) dut (
      .clk(clk), .reset_n(reset_n),
      .reg_valid(reg_valid), .reg_write(reg_write), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ready(reg_ready),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
      .burst_wr(burst_wr), .burst_addr(burst_addr), .burst_len(burst_len),
      .burst_32bit(burst_32bit), .burst_wdata(burst_wdata),
      .burst_data_req(burst_data_req), .burst_data_done(burst_data_done)
   );

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [63:0] src [$];
   logic [31:0] got [$];
   logic [24:0] seen_addr;
   logic [10:0] seen_len;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Q32.32 -> Q16.16 by floor((x + 0.5 LSB) / 2^16), bias, clamp, ReLU.
   function automatic logic [31:0] model(input logic [63:0] r, input logic [31:0] b,
                                         input bit relu, output bit sat);
      logic signed [95:0] x, q, t;
      x = $signed({{32{r[63]}}, r}) + 96'sd32768;
      q = x / 96'sd65536;
      if (x < 0 && (x % 96'sd65536) != 0) q = q - 96'sd1;
      t = q + $signed({{64{b[31]}}, b});
      sat = 1'b0;
      if (t > 96'sd2147483647) begin t = 96'sd2147483647; sat = 1'b1; end
      else if (t < -96'sd2147483648) begin t = -96'sd2147483648; sat = 1'b1; end
      if (relu && t < 0) t = '0;
      return t[31:0];
   endfunction

   task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      reg_valid = 1'b1; reg_write = 1'b1; reg_addr = a; reg_wdata = d;
      @(negedge clk);
      reg_valid = 1'b0; reg_write = 1'b0; reg_addr = 8'h00; reg_wdata = '0;
   endtask

   task automatic reg_rd(input logic [7:0] a, output logic [31:0] d);
      reg_addr = a;
      #1 d = reg_rdata;
      reg_addr = 8'h00;
   endtask

   task automatic run_job(input logic [8:0] cnt, input logic [23:0] addr,
                          input logic [31:0] bias, input bit relu,
                          input int stall, input int gap, input string tag);
      int n_eff, acc, reqs, cyc, last_acc, wr_cyc, n_wr, sat_m;
      bit in_burst, done_sent, s;
      logic [31:0] rd;
      logic [31:0] exp_w [$];
      n_eff = (cnt > 9'd256) ? 256 : int'(cnt);
      sat_m = 0;
      for (int i = 0; i < n_eff; i++) begin
         exp_w.push_back(model(src[i], bias, relu, s));
         if (s && sat_m < 65535) sat_m++;
      end
      reg_wr(8'h04, {23'd0, cnt});
      reg_wr(8'h08, {8'd0, addr});
      reg_wr(8'h0C, bias);
      reg_wr(8'h00, {30'd0, relu, 1'b1});
      reg_wr(8'h04, {23'd0, ~cnt});          // must be ignored while busy
      got.delete();
      acc = 0; reqs = 0; cyc = 0; last_acc = -1; wr_cyc = -1; n_wr = 0;
      in_burst = 0; done_sent = 0;
      while (cyc < 6000) begin
         @(negedge clk);
         cyc++;
         res_valid = 1'b0; burst_data_req = 1'b0; burst_data_done = 1'b0;
         if (done_sent && !reg_rdata[0]) break;
         if (burst_wr) begin
            n_wr++; wr_cyc = cyc; seen_addr = burst_addr; seen_len = burst_len; in_burst = 1;
         end else if (in_burst && !done_sent) begin
            if (reqs == n_eff) begin
               burst_data_done = 1'b1; done_sent = 1;
            end else if (int'($urandom_range(99)) >= gap) begin
               burst_data_req = 1'b1; got.push_back(burst_wdata); reqs++;
            end
         end
         if (res_ready && acc < src.size() && int'($urandom_range(99)) >= stall) begin
            res_valid = 1'b1; res_data = src[acc]; acc++; last_acc = cyc;
         end
      end
      res_valid = 1'b0; burst_data_req = 1'b0; burst_data_done = 1'b0;
      check({tag, "_complete"}, 64'(done_sent && !reg_rdata[0]), 64'd1);
      check({tag, "_accepted"}, 64'(acc), 64'(n_eff));
      check({tag, "_burst_wr_pulses"}, 64'(n_wr), 64'd1);
      check({tag, "_burst_addr"}, 64'(seen_addr), 64'({addr, 1'b0}));
      check({tag, "_burst_len"}, 64'(seen_len), 64'(2 * n_eff));
      check({tag, "_latency"}, 64'(wr_cyc - last_acc), 64'd3);
      check({tag, "_nwords"}, 64'(got.size()), 64'(n_eff));
      for (int i = 0; i < n_eff && i < got.size(); i++)
         check($sformatf("%s_word%0d", tag, i), 64'(got[i]), 64'(exp_w[i]));
      reg_rd(8'h10, rd);
      check({tag, "_sat_count"}, 64'(rd), 64'(sat_m));
      reg_rd(8'h00, rd);
      check({tag, "_sat_flag"}, 64'(rd[2]), 64'(sat_m != 0));
      reg_rd(8'h04, rd);
      check({tag, "_count_kept"}, 64'(rd), 64'(cnt));
   endtask

   typedef struct {
      logic [63:0] res;
      logic [31:0] bias;
      bit          relu;
      logic [31:0] exp;
      logic [15:0] sat;
   } vec_t;

   initial begin
      vec_t tbl [12];
      logic [31:0] rd;
      logic [31:0] bb;
      logic [63:0] r;
      int k;
      bit seen;

      tbl[0]  = '{64'h0000_0001_0000_8000, 32'h0000_0000, 0, 32'h0001_0001, 16'd0};
      tbl[1]  = '{64'hFFFF_FFFF_FFFF_8000, 32'h0000_0000, 0, 32'h0000_0000, 16'd0};
      tbl[2]  = '{64'h0001_0000_0000_0000, 32'h0000_0000, 0, 32'h7FFF_FFFF, 16'd1};
      tbl[3]  = '{64'h8000_0000_0000_0000, 32'h0000_0000, 0, 32'h8000_0000, 16'd1};
      tbl[4]  = '{64'hFFFF_FFFF_0000_0000, 32'h0000_8000, 1, 32'h0000_0000, 16'd0};
      tbl[5]  = '{64'hFFFF_FFFF_0000_0000, 32'h0000_8000, 0, 32'hFFFF_8000, 16'd0};
      tbl[6]  = '{64'hFFFF_FFFF_FFFF_7FFF, 32'h0000_0000, 0, 32'hFFFF_FFFF, 16'd0};
      tbl[7]  = '{64'h0000_7FFF_FFFF_0000, 32'h0000_0001, 0, 32'h7FFF_FFFF, 16'd1};
      tbl[8]  = '{64'h0000_7FFF_FFFF_0000, 32'h0000_0000, 0, 32'h7FFF_FFFF, 16'd0};
      tbl[9]  = '{64'hFFFF_8000_0000_0000, 32'h0000_0000, 0, 32'h8000_0000, 16'd0};
      tbl[10] = '{64'h0000_0002_0000_0000, 32'hFFFF_0000, 1, 32'h0001_0000, 16'd0};
      tbl[11] = '{64'h7FFF_FFFF_FFFF_FFFF, 32'h0000_0000, 0, 32'h7FFF_FFFF, 16'd1};

      reset_n = 1'b0; reg_valid = 1'b0; reg_write = 1'b0; reg_addr = '0; reg_wdata = '0;
      res_valid = 1'b0; res_data = '0; burst_data_req = 1'b0; burst_data_done = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      for (int a = 0; a < 5; a++) begin
         reg_rd(8'(a * 4), rd);
         check($sformatf("reset_reg%0d", a), 64'(rd), 64'd0);
      end
      check("reset_res_ready", 64'(res_ready), 64'd0);
      check("reset_burst_wr", 64'(burst_wr), 64'd0);
      check("reset_burst_addr", 64'(burst_addr), 64'd0);
      check("reset_burst_len", 64'(burst_len), 64'd0);
      check("reset_burst_wdata", 64'(burst_wdata), 64'd0);
      check("burst_32bit", 64'(burst_32bit), 64'd1);

      for (int i = 0; i < 12; i++) begin
         src.delete(); src.push_back(tbl[i].res);
         run_job(9'd1, 24'h00_0100, tbl[i].bias, tbl[i].relu, 0, 0, $sformatf("vec%0d", i));
         check($sformatf("vec%0d_table_word", i), 64'((got.size() > 0) ? got[0] : 32'hDEAD_BEEF), 64'(tbl[i].exp));
         reg_rd(8'h10, rd);
         check($sformatf("vec%0d_table_sat", i), 64'(rd), 64'(tbl[i].sat));
      end

      src.delete();
      src.push_back(64'h0001_0000_0000_0000);
      src.push_back(64'h8000_0000_0000_0000);
      run_job(9'd2, 24'h00_0200, 32'h0, 0, 0, 0, "satpair");
      reg_rd(8'h10, rd);
      check("satpair_sat_count_2", 64'(rd), 64'd2);

      src.delete();
      for (int i = 0; i < 4; i++) src.push_back(64'(i + 1) << 32);
      run_job(9'd4, 24'h00_1000, 32'h0, 0, 40, 50, "count4");
      check("count4_addr_2000", 64'(seen_addr), 64'h2000);
      check("count4_len_8", 64'(seen_len), 64'd8);
      check("count4_word3", 64'((got.size() == 4) ? got[3] : 32'hDEAD_BEEF), 64'h0004_0000);

      for (int j = 0; j < 6; j++) begin
         src.delete();
         k = int'($urandom_range(24, 1));
         for (int i = 0; i < k; i++) begin
            r = {$urandom, $urandom};
            case ($urandom_range(2))
               0: ;
               1: r = {{16{r[47]}}, r[47:0]};
               default: r = {{24{r[39]}}, r[39:0]};
            endcase
            src.push_back(r);
         end
         bb = $urandom;
         if ($urandom_range(1) == 1) bb = {{8{bb[23]}}, bb[23:0]};
         run_job(9'(k), 24'($urandom), bb, bit'($urandom_range(1)), 30, 30, $sformatf("rnd%0d", j));
      end

      src.delete();
      for (int i = 0; i < 300; i++) src.push_back({{24{1'b0}}, 8'(i), 32'($urandom)});
      run_job(9'd300, 24'h00_4000, 32'h0, 0, 10, 10, "clamp300");
      check("clamp300_len_512", 64'(seen_len), 64'd512);

      reg_wr(8'h04, 32'd0);
      reg_wr(8'h00, 32'd1);
      reg_rd(8'h00, rd);
      check("count0_busy_c1", 64'(rd[0]), 64'd1);
      check("count0_no_wr_c1", 64'(burst_wr), 64'd0);
      @(negedge clk);
      reg_rd(8'h00, rd);
      check("count0_busy_c2", 64'(rd[0]), 64'd1);
      check("count0_no_wr_c2", 64'(burst_wr), 64'd0);
      @(negedge clk);
      reg_rd(8'h00, rd);
      check("count0_idle_c3", 64'(rd[0]), 64'd0);

      reg_wr(8'h04, 32'd4);
      reg_wr(8'h08, 32'h55);
      reg_wr(8'h00, 32'd1);
      k = 0; seen = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         res_valid = 1'b0;
         if (burst_wr) begin seen = 1; break; end
         if (res_ready && k < 4) begin res_valid = 1'b1; res_data = 64'(k + 7) << 32; k++; end
      end
      res_valid = 1'b0;
      check("rst_reached_flush", 64'(seen), 64'd1);
      @(negedge clk);
      burst_data_req = 1'b1;
      @(negedge clk);
      burst_data_req = 1'b0;
      reset_n = 1'b0;
      @(negedge clk);
      reg_rd(8'h00, rd);
      check("rst_busy", 64'(rd[0]), 64'd0);
      check("rst_res_ready", 64'(res_ready), 64'd0);
      check("rst_burst_wr", 64'(burst_wr), 64'd0);
      check("rst_burst_addr", 64'(burst_addr), 64'd0);
      check("rst_burst_len", 64'(burst_len), 64'd0);
      check("rst_burst_wdata", 64'(burst_wdata), 64'd0);
      reg_rd(8'h04, rd);
      check("rst_count_reg", 64'(rd), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);
      reg_rd(8'h00, rd);
      check("rst_stays_idle", 64'(rd[0]), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
